// File: rtl/chunked_adder.sv
// chunked_adder: multi-cycle WIDTH-bit adder that ripples CHUNK bits per clock, LSB chunk first.
// Reports sum, carry-out and signed overflow through a start/busy/done handshake.
// Optional feature macro: CHUNKED_ADDER_SUB_EN adds a subtract mode selected by op.
module chunked_adder #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             op,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);

  localparam int unsigned N    = WIDTH / CHUNK;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q;
  logic [WIDTH-1:0]  a_q;      // operand A, shifted right one chunk per RUN edge
  logic [WIDTH-1:0]  b_q;      // operand B' (possibly inverted), shifted likewise
  logic [WIDTH-1:0]  acc_q;    // partial result, filled from the top one chunk at a time
  logic              cy_q;     // running carry between chunks
  logic [CntW-1:0]   cnt_q;

  logic [WIDTH-1:0]  b_seed;
  logic              cy_seed;
  logic [CHUNK:0]    chunk_res;
  logic [WIDTH-1:0]  acc_d;
  logic              last_chunk;
  logic              msb_cin;

`ifdef CHUNKED_ADDER_SUB_EN
  // Subtract as a + ~b + 1; cin has no effect in that mode.
  always_comb begin
    b_seed  = op ? ~b : b;
    cy_seed = op ? 1'b1 : cin;
  end
`else
  logic unused_op;
  assign unused_op = op;

  // Plain add: operands pass straight through.
  always_comb begin
    b_seed  = b;
    cy_seed = cin;
  end
`endif

  // Current chunk add, accumulator insert and MSB carry-in recovery.
  always_comb begin
    chunk_res  = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, cy_q};
    acc_d      = (acc_q >> CHUNK) | (WIDTH'(chunk_res[CHUNK-1:0]) << (WIDTH - CHUNK));
    last_chunk = (cnt_q == CntW'(N - 1));
    // Carry into the top bit is recoverable from the top bit's sum and operands.
    msb_cin    = a_q[CHUNK-1] ^ b_q[CHUNK-1] ^ chunk_res[CHUNK-1];
  end

  // Control FSM, operand/accumulator datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      cy_q     <= 1'b0;
      cnt_q    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum      <= '0;
      carry    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          done <= 1'b0;
          if (start) begin
            a_q     <= a;
            b_q     <= b_seed;
            cy_q    <= cy_seed;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy    <= 1'b1;
            state_q <= StRun;
          end else begin
            state_q <= StIdle;
          end
        end
        StRun: begin
          a_q   <= a_q >> CHUNK;
          b_q   <= b_q >> CHUNK;
          cy_q  <= chunk_res[CHUNK];
          acc_q <= acc_d;
          cnt_q <= cnt_q + CntW'(1);
          if (last_chunk) begin
            sum      <= acc_d;
            carry    <= chunk_res[CHUNK];
            overflow <= msb_cin ^ chunk_res[CHUNK];
            busy     <= 1'b0;
            done     <= 1'b1;
            state_q  <= StDone;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/chunked_adder.md
# chunked_adder

Multi-cycle parametrised adder for the ALU datapath and the successor of the single-cycle half adder. Adds two WIDTH-bit operands with carry-in, CHUNK bits per clock, starting at the LSB chunk. It reports the sum, carry-out and signed overflow through a start/busy/done handshake. The optional subtract mode turns it into the ALU's sequential add/sub unit.

## Interface
Parameters:
- WIDTH, 32: operand and sum width in bits.
- CHUNK, 8: bits processed per cycle. WIDTH % CHUNK must be 0 and CHUNK ≥ 1. N = WIDTH/CHUNK.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only in IDLE or DONE.
- a  in  WIDTH  operand A, unsigned or two's complement.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in; used in add mode only.
- op  in  1  0 = add, 1 = subtract. Ignored unless CHUNKED_ADDER_SUB_EN is defined.
- busy  out  1  high while chunks are being processed.
- done  out  1  one-cycle pulse when the result is valid.
- sum  out  WIDTH  result, registered and held until the next completion.
- carry  out  1  carry-out of the MSB. In subtract mode 1 means no borrow.
- overflow  out  1  signed overflow: carry into MSB XOR carry out of MSB.

## Operation
- States: IDLE, RUN, DONE. Reset puts the block in IDLE.
- Reset values: busy=0, done=0, sum=0, carry=0, overflow=0. Internal chunk counter and accumulator are also 0.
- Starting a job (IDLE or DONE, start=1):
  - latch a;
  - latch b, or ~b when op=1 and the macro is enabled;
  - latch the carry seed: cin in add mode, 1 in subtract mode;
  - clear the chunk counter and go to RUN.
- RUN, one chunk per edge:
  - chunk i adds A[i*CHUNK +: CHUNK] + B' chunk + running carry;
  - the partial result goes into the internal accumulator, not into sum;
  - the running carry updates;
  - on the edge that processes chunk N-1, go to DONE.
- Completion: on that final edge, sum, carry and overflow load together. Overflow uses the carry into bit WIDTH-1, which is captured inside the last chunk.
- DONE lasts one cycle:
  - done=1;
  - start=1 launches the next job back to back;
  - otherwise return to IDLE.
- start during RUN is ignored. It is neither queued nor allowed to corrupt the in-flight job.
- Operand inputs are not sampled after the start edge; they may change freely during RUN.
- Arithmetic is modulo 2^WIDTH. Unsigned carry and signed overflow are reported independently.
- Reset asserted mid-operation aborts the job at once. All outputs return to reset values, no done is produced, and the partial result is discarded.

## Timing
- Edge E0: start sampled high in IDLE or DONE. busy=1 after E0.
- Edges E1..EN: chunks 0..N-1 are processed.
- After EN: busy=0, done=1, and sum/carry/overflow are valid and stable.
- After E(N+1): done=0. Results hold until the next completion or reset.
- Latency: N+1 edges from start to done-high. Throughput: one result per N+1 cycles with back-to-back starts.
- CHUNK = WIDTH (N=1): one RUN edge, so done appears 2 edges after start.
- busy and done are never high together.
- Reset is asynchronous on assertion. Release is synchronised externally; the block resumes in IDLE on the first edge after release.

## Configuration
- CHUNKED_ADDER_SUB_EN defined:
  - op=1 selects subtraction, sum = a − b, computed as a + ~b + 1;
  - cin is ignored;
  - carry=1 means a ≥ b unsigned.
- Not defined:
  - op is ignored and the block always adds a + b + cin;
  - no inversion logic is synthesised.

## Test plan
WIDTH=32, CHUNK=8, N=4 unless stated.
- Basic add: a=5, b=7, cin=0, start at E0 → done=1 after E4 only; sum=12, carry=0, overflow=0; busy high for E1..E4.
- Unsigned wrap with carry-in: a=0xFFFFFFFF, b=0, cin=1 → sum=0x00000000, carry=1, overflow=0.
- Signed overflow: a=0x7FFFFFFF, b=1, cin=0 → sum=0x80000000, carry=0, overflow=1. The carry must ripple across all 4 chunks.
- Subtract (macro on): a=3, b=5, op=1 → sum=0xFFFFFFFE, carry=0, overflow=0. With the macro off, the same stimulus with cin=0 gives sum=8.
- Handshake:
  - start pulsed again at E2 with a=1, b=1 → ignored, first result unchanged;
  - start held high in the DONE cycle with a=10, b=20 → second done 5 edges later, sum=30.
- Reset mid-run and N=1 case:
  - rst_n low after E2 → all outputs 0 immediately; no done appears for 10 cycles after release without a new start;
  - rerun with CHUNK=32 → done 2 edges after start.
